// File: rtl/frame_stream_scheduler.sv
// Frame sequencer between a pixel stream and the image-processing core:
// meters input by line-buffer credits, honours output back-pressure, tracks frame completion.
module frame_stream_scheduler #(
  parameter int IMG_WIDTH   = 512,
  parameter int IMG_HEIGHT  = 512,
  parameter int PRIME_LINES = 4,
  parameter int OUT_PIXELS  = IMG_WIDTH * IMG_HEIGHT
) (
  input  logic       axi_clk,
  input  logic       axi_reset_n,
  input  logic       start,
  input  logic [3:0] cfg_opcode,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       p_data_valid,
  output logic [7:0] p_data,
  output logic [3:0] p_opcode,
  input  logic       p_intr,
  input  logic       p_prog_full,
  input  logic       m_beat,
  output logic       busy,
  output logic       frame_done,
  output logic       err_credit
);

  localparam int PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int LW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW = $clog2(PRIME_LINES + 1);
  localparam int OW = $clog2(OUT_PIXELS + 1);

  localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_WIDTH - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(PRIME_LINES);
  localparam logic [OW-1:0] OUT_MAX   = OW'(OUT_PIXELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [3:0]    opcode_q, opcode_d;
  logic          err_q, err_d;
  logic          pvalid_q, pvalid_d;
  logic [7:0]    pdata_q, pdata_d;

  logic ready_c;
  logic xfer_c;
  logic line_end_c;
  logic frame_end_c;
  logic intr_ok_c;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    credits_d  = credits_q;
    out_cnt_d  = out_cnt_q;
    opcode_d   = opcode_q;
    err_d      = err_q;

    // Ready never looks at s_valid, so upstream may wait on it freely.
    ready_c     = (state_q == STREAM) && (credits_q != '0) && !p_prog_full;
    xfer_c      = s_valid && ready_c;
    line_end_c  = xfer_c && (pix_cnt_q == PIX_LAST);
    frame_end_c = line_end_c && (line_cnt_q == LINE_LAST);
    intr_ok_c   = p_intr && ((state_q == STREAM) || (state_q == DRAIN));

    pvalid_d = xfer_c;
    pdata_d  = xfer_c ? s_data : pdata_q;

    if (xfer_c) begin
      if (line_end_c) begin
        pix_cnt_d  = '0;
        line_cnt_d = line_cnt_q + LW'(1);
      end else begin
        pix_cnt_d = pix_cnt_q + PW'(1);
      end
    end

    // A returned line and a consumed line in the same cycle cancel out.
    case ({line_end_c, intr_ok_c})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + CW'(1);
        end
      end
      default: credits_d = credits_q;
    endcase

    if ((state_q != IDLE) && m_beat && (out_cnt_q != OUT_MAX)) begin
      out_cnt_d = out_cnt_q + OW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = STREAM;
          opcode_d   = cfg_opcode;
          credits_d  = CRED_MAX;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          out_cnt_d  = '0;
          err_d      = 1'b0;
        end
      end
      STREAM: begin
        if (frame_end_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_cnt_d == OUT_MAX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      credits_q  <= '0;
      out_cnt_q  <= '0;
      opcode_q   <= '0;
      err_q      <= 1'b0;
      pvalid_q   <= 1'b0;
      pdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      credits_q  <= credits_d;
      out_cnt_q  <= out_cnt_d;
      opcode_q   <= opcode_d;
      err_q      <= err_d;
      pvalid_q   <= pvalid_d;
      pdata_q    <= pdata_d;
    end
  end

  assign s_ready      = ready_c;
  assign p_data_valid = pvalid_q;
  assign p_data       = pdata_q;
  assign p_opcode     = opcode_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == DONE);
  assign err_credit   = err_q;

endmodule

// File: tb/tb_frame_stream_scheduler.sv
// Directed bench for frame_stream_scheduler with an 8x6 frame and 4 line credits.
module tb_frame_stream_scheduler;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int P   = 4;
  localparam int OUT = 48;

  logic       axi_clk     = 1'b0;
  logic       axi_reset_n = 1'b0;
  logic       start       = 1'b0;
  logic [3:0] cfg_opcode  = 4'h0;
  logic       s_valid     = 1'b0;
  logic [7:0] s_data      = 8'h00;
  logic       s_ready;
  logic       p_data_valid;
  logic [7:0] p_data;
  logic [3:0] p_opcode;
  logic       p_intr      = 1'b0;
  logic       p_prog_full = 1'b0;
  logic       m_beat      = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       err_credit;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int fd_cnt   = 0;

  frame_stream_scheduler #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PRIME_LINES(P),
    .OUT_PIXELS (OUT)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .start       (start),
    .cfg_opcode  (cfg_opcode),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .p_data_valid(p_data_valid),
    .p_data      (p_data),
    .p_opcode    (p_opcode),
    .p_intr      (p_intr),
    .p_prog_full (p_prog_full),
    .m_beat      (m_beat),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_credit  (err_credit)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample the handshake before the edge, then verify the registered pixel path.
  task automatic step();
    logic       xfer;
    logic [7:0] sent;
    #1;
    xfer = s_valid && s_ready;
    sent = s_data;
    @(posedge axi_clk);
    #1;
    check("p_data_valid", 32'(p_data_valid), 32'(xfer));
    if (xfer) begin
      check("p_data", 32'(p_data), 32'(sent));
      xfers++;
      $display("xfer %0d data=%0h", xfers, sent);
      s_data = s_data + 8'd1;
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain_frame();
    fd_cnt = 0;
    m_beat = 1'b1;
    run(OUT);
    m_beat = 1'b0;
    check("frame_done_on_last_beat", 32'(frame_done), 32'd1);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    step();
    check("frame_done_single", 32'(frame_done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #3;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_p_data_valid", 32'(p_data_valid), 32'd0);
    check("rst_p_data", 32'(p_data), 32'd0);
    check("rst_p_opcode", 32'(p_opcode), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err_credit", 32'(err_credit), 32'd0);
    @(posedge axi_clk);
    #3 axi_reset_n = 1'b1;
    @(posedge axi_clk);
    #1;

    // Frame 1: no credit returns -> four lines only
    cfg_opcode = 4'h3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("f1_busy", 32'(busy), 32'd1);
    check("f1_p_opcode", 32'(p_opcode), 32'h3);
    s_valid = 1'b1;
    run(40);
    check("f1_xfers_primed", 32'(xfers), 32'd32);
    check("f1_s_ready_starved", 32'(s_ready), 32'd0);
    check("f1_busy_starved", 32'(busy), 32'd1);

    s_valid = 1'b0;
    p_intr = 1'b1;
    run(2);
    p_intr = 1'b0;
    s_valid = 1'b1;
    run(20);
    check("f1_xfers_total", 32'(xfers), 32'd48);
    check("f1_drain_busy", 32'(busy), 32'd1);
    check("f1_drain_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    drain_frame();

    // Frame 2: back-pressure, coincident credit, mid-frame start, credit overflow
    xfers = 0;
    s_data = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    s_valid = 1'b1;
    run(3);
    p_prog_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("pf_s_ready_low", 32'(s_ready), 32'd0);
      step();
    end
    p_prog_full = 1'b0;
    #1;
    check("pf_s_ready_back", 32'(s_ready), 32'd1);
    run(13);
    check("f2_xfers_2lines", 32'(xfers), 32'd16);

    s_valid = 1'b0;
    cfg_opcode = 4'h7;
    start = 1'b1;
    step();
    start = 1'b0;
    check("midframe_p_opcode", 32'(p_opcode), 32'h3);
    check("midframe_busy", 32'(busy), 32'd1);
    check("midframe_s_ready", 32'(s_ready), 32'd1);

    s_valid = 1'b1;
    run(8);
    check("f2_xfers_3lines", 32'(xfers), 32'd24);
    run(7);
    p_intr = 1'b1;
    step();
    p_intr = 1'b0;
    check("f2_xfers_4lines", 32'(xfers), 32'd32);
    #1;
    check("coincident_credit_ready", 32'(s_ready), 32'd1);
    run(8);
    check("f2_xfers_5lines", 32'(xfers), 32'd40);
    #1;
    check("credits_exhausted", 32'(s_ready), 32'd0);

    s_valid = 1'b0;
    p_intr = 1'b1;
    run(4);
    p_intr = 1'b0;
    check("err_before_overflow", 32'(err_credit), 32'd0);
    p_intr = 1'b1;
    step();
    p_intr = 1'b0;
    check("err_on_overflow", 32'(err_credit), 32'd1);
    s_valid = 1'b1;
    run(8);
    check("f2_xfers_total", 32'(xfers), 32'd48);
    check("f2_drain_busy", 32'(busy), 32'd1);
    check("f2_drain_s_ready", 32'(s_ready), 32'd0);
    check("err_sticky", 32'(err_credit), 32'd1);
    s_valid = 1'b0;
    drain_frame();

    // Frame 3: new opcode latched, then asynchronous reset mid-line
    xfers = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("f3_p_opcode", 32'(p_opcode), 32'h7);
    check("f3_err_cleared", 32'(err_credit), 32'd0);
    check("f3_busy", 32'(busy), 32'd1);
    s_valid = 1'b1;
    run(3);
    check("f3_p_data_valid_pre_rst", 32'(p_data_valid), 32'd1);
    #2 axi_reset_n = 1'b0;
    #1;
    check("arst_s_ready", 32'(s_ready), 32'd0);
    check("arst_p_data_valid", 32'(p_data_valid), 32'd0);
    check("arst_p_data", 32'(p_data), 32'd0);
    check("arst_p_opcode", 32'(p_opcode), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    s_valid = 1'b0;
    @(posedge axi_clk);
    @(posedge axi_clk);
    #3 axi_reset_n = 1'b1;
    @(posedge axi_clk);
    #1;

    xfers = 0;
    s_data = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    check("f4_p_opcode", 32'(p_opcode), 32'h7);
    s_valid = 1'b1;
    run(40);
    check("f4_xfers_fresh_credits", 32'(xfers), 32'd32);
    check("f4_s_ready_starved", 32'(s_ready), 32'd0);
    s_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
